encoder_scheduler: RTL and testbench

- Top-level round sequencer for the matrix encoder. It runs the per-stage controllers (column parity, rotate, permute, nonlinear, round-constant) in fixed order for NUM_ROUNDS rounds over one loaded state.
- Each stage is started with a one-cycle start pulse, and the scheduler waits for that stage's one-cycle done pulse.
- It brackets the run with a state-load and a state-store step.
- It sits above the stage controllers and below the testbench/file I/O glue.

---
 rtl/encoder_scheduler_if.sv | 35 +++
 rtl/encoder_scheduler.sv | 154 +++++++++++++++
 tb/tb_encoder_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_scheduler_if.sv
// encoder_scheduler_if: command, stage-handshake and status bundle for the
// encoder round scheduler. The master side is the glue/stage-controller side
// that issues start/abort and returns stage_done pulses; the slave side is the
// scheduler itself.
interface encoder_scheduler_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_ROUNDS = 24
);
    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  load_en;
    logic                  store_en;
    logic [NUM_STAGES-1:0] stage_start;
    logic [STAGE_W-1:0]    stage_idx;
    logic [ROUND_W-1:0]    round_idx;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, abort, stage_done,
        input  load_en, store_en, stage_start, stage_idx, round_idx,
               busy, done, error
    );

    modport slave (
        input  start, abort, stage_done,
        output load_en, store_en, stage_start, stage_idx, round_idx,
               busy, done, error
    );
endinterface

// File: rtl/encoder_scheduler.sv
// encoder_scheduler: top-level round sequencer for the matrix encoder.
// Loads the state, runs NUM_STAGES stage controllers in fixed order for
// NUM_ROUNDS rounds (start pulse out, done pulse back), then stores the state.
// Outputs are Moore-decoded from the state and the registered counters.
// Optional feature macro: SCHED_TIMEOUT_EN adds a per-stage WAIT watchdog
// (STAGE_TIMEOUT cycles) that moves the sequencer into a sticky ERROR state.
module encoder_scheduler #(
    parameter int NUM_STAGES    = 5,
    parameter int NUM_ROUNDS    = 24,
    parameter int STAGE_TIMEOUT = 4096
) (
    input logic                clk,
    input logic                rst,
    encoder_scheduler_if.slave bus
);
    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               sel_done;

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(STAGE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STAGE_TIMEOUT);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    // Without the watchdog the timeout has no meaning; keep it referenced so
    // the parameter list stays identical across both builds.
    logic unused_timeout;
    assign unused_timeout = (STAGE_TIMEOUT == 0);
`endif

    // Only the done bit of the stage currently being waited on matters.
    assign sel_done = bus.stage_done[stage_q];

    // State and counter registers; reset returns to IDLE with counters at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            round_q <= '0;
`ifdef SCHED_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
`ifdef SCHED_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Next-state and counter update; abort outside IDLE overrides everything.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        round_d = round_q;
`ifdef SCHED_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
`ifdef SCHED_TIMEOUT_EN
            IDLE: begin
`else
            IDLE, ERROR: begin
`endif
                stage_d = '0;
                round_d = '0;
`ifdef SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
                if (bus.start) state_d = LOAD;
            end
            LOAD:  state_d = ISSUE;
            ISSUE: begin
`ifdef SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
`ifdef SCHED_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
`endif
                if (sel_done) begin
                    if (stage_q != LAST_STAGE) begin
                        stage_d = stage_q + 1'b1;
                        state_d = ISSUE;
                    end else if (round_q != LAST_ROUND) begin
                        stage_d = '0;
                        round_d = round_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = STORE;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if ((wd_q + 1'b1) >= WD_LIMIT) begin
                    state_d = ERROR;
                end
`endif
            end
            STORE: state_d = DONE;
            DONE:  state_d = IDLE;
`ifdef SCHED_TIMEOUT_EN
            ERROR: state_d = ERROR;
`endif
            default: state_d = IDLE;
        endcase

        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            stage_d = '0;
            round_d = '0;
`ifdef SCHED_TIMEOUT_EN
            wd_d    = '0;
`endif
        end
    end

    // Moore output decode from the present state and registered counters.
    always_comb begin
        bus.load_en     = (state_q == LOAD);
        bus.store_en    = (state_q == STORE);
        bus.done        = (state_q == DONE);
        bus.stage_idx   = stage_q;
        bus.round_idx   = round_q;
        bus.stage_start = '0;
        if (state_q == ISSUE) bus.stage_start[stage_q] = 1'b1;
`ifdef SCHED_TIMEOUT_EN
        bus.busy        = (state_q != IDLE);
        bus.error       = (state_q == ERROR);
`else
        bus.busy        = (state_q != IDLE) && (state_q != ERROR);
        bus.error       = 1'b0;
`endif
    end
endmodule

// File: tb/tb_encoder_scheduler.sv
// tb_encoder_scheduler: self-checking bench for encoder_scheduler.
// Acts as the stage controllers with randomized stage latencies and predicts
// every event cycle from the round/stage timing rules.
// Build with SCHED_TIMEOUT_EN to exercise the watchdog with STAGE_TIMEOUT=16.
module tb_encoder_scheduler;
    localparam int NS = 5;
    localparam int NR = 24;
`ifdef SCHED_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   rel = 0;

    encoder_scheduler_if #(.NUM_STAGES(NS), .NUM_ROUNDS(NR)) bus ();

    encoder_scheduler #(
        .NUM_STAGES(NS),
        .NUM_ROUNDS(NR),
        .STAGE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports each check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the master-side inputs.
    task automatic applyStimulus(input logic st, input logic ab, input logic [NS-1:0] sd);
        bus.start      = st;
        bus.abort      = ab;
        bus.stage_done = sd;
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_load"}, 32'(bus.load_en), 0);
        checkOutput({tag, "_store"}, 32'(bus.store_en), 0);
        checkOutput({tag, "_done"}, 32'(bus.done), 0);
        checkOutput({tag, "_start"}, 32'(bus.stage_start), 0);
        checkOutput({tag, "_sidx"}, 32'(bus.stage_idx), 0);
        checkOutput({tag, "_ridx"}, 32'(bus.round_idx), 0);
        checkOutput({tag, "_err"}, 32'(bus.error), 0);
    endtask

    // One encode. dFix=0 picks random latencies. abortR/abortS interrupt with
    // abort in the first WAIT of that step; resetR resets in round resetR.
    task automatic runEncode(input int dFix, input int abortR, input int abortS,
                             input int resetR, input bit nominal);
        int acc;
        int d;
        logic [NS-1:0] noise;
        applyStimulus(1'b1, 1'b0, '0);
        rel = 0;
        stepCycle();
        checkOutput("load_en", 32'(bus.load_en), 1);
        checkOutput("busy_load", 32'(bus.busy), 1);
        applyStimulus(1'b0, 1'b0, '0);
        stepCycle();
        acc = 2;
        for (int r = 0; r < NR; r++) begin
            for (int s = 0; s < NS; s++) begin
                checkOutput("issue_cycle", rel, acc);
                checkOutput("stage_start", 32'(bus.stage_start), 32'(1 << s));
                checkOutput("stage_idx", 32'(bus.stage_idx), s);
                checkOutput("round_idx", 32'(bus.round_idx), r);
                d = (dFix != 0) ? dFix : int'($urandom_range(1, 4));
                stepCycle();
                if (r == abortR && s == abortS) begin
                    applyStimulus(1'b0, 1'b1, '0);
                    stepCycle();
                    applyStimulus(1'b0, 1'b0, '0);
                    checkIdle("abort");
                    for (int k = 0; k < 4; k++) begin
                        stepCycle();
                        checkIdle("post_abort");
                    end
                    return;
                end
                if (r == resetR && s == 0) begin
                    rst = 1'b0;
                    #1;
                    checkIdle("async_reset");
                    applyStimulus(1'b0, 1'b0, '0);
                    @(negedge clk);
                    rst = 1'b1;
                    stepCycle();
                    checkIdle("after_reset");
                    return;
                end
                for (int j = 1; j <= d; j++) begin
                    checkOutput("wait_quiet", 32'(bus.stage_start), 0);
                    checkOutput("wait_busy", 32'(bus.busy), 1);
                    noise = NS'($urandom) & ~NS'(1 << s);
                    if (j == d) noise = noise | NS'(1 << s);
                    applyStimulus(1'($urandom_range(0, 1)), 1'b0, noise);
                    stepCycle();
                    applyStimulus(1'b0, 1'b0, '0);
                end
                acc += 1 + d;
            end
        end
        checkOutput("store_cycle", rel, acc);
        checkOutput("store_en", 32'(bus.store_en), 1);
        checkOutput("store_quiet", 32'(bus.stage_start), 0);
        if (nominal) checkOutput("store_cycle_nominal", rel, 2 + NR * NS * 3);
        stepCycle();
        checkOutput("done_cycle", rel, acc + 1);
        checkOutput("done", 32'(bus.done), 1);
        checkOutput("done_sidx", 32'(bus.stage_idx), NS - 1);
        checkOutput("done_ridx", 32'(bus.round_idx), NR - 1);
        stepCycle();
        checkOutput("idle_busy", 32'(bus.busy), 0);
        checkOutput("idle_done", 32'(bus.done), 0);
    endtask

    // Bring the sequencer to the first WAIT cycle of stage 0, round 0.
    task automatic enterFirstWait();
        applyStimulus(1'b1, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0);
        stepCycle();
        checkOutput("first_issue", 32'(bus.stage_start), 1);
        stepCycle();
    endtask

    task automatic abortToIdle(input string tag);
        applyStimulus(1'b0, 1'b1, '0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0);
        checkIdle(tag);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        @(negedge clk);
        rst = 1'b1;
        stepCycle();
        checkIdle("released");

        // Nominal run with D=2, then a back-to-back random-latency run.
        runEncode(2, -1, -1, -1, 1'b1);
        runEncode(0, -1, -1, -1, 1'b0);

        // Wrong-stage done while waiting on stage 1.
        enterFirstWait();
        applyStimulus(1'b0, 1'b0, NS'(1));
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("ws_issue1", 32'(bus.stage_start), 2);
        stepCycle();
        applyStimulus(1'b0, 1'b0, NS'(1 << 3));
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("ws_ignored_start", 32'(bus.stage_start), 0);
        checkOutput("ws_ignored_busy", 32'(bus.busy), 1);
        checkOutput("ws_ignored_sidx", 32'(bus.stage_idx), 1);
        applyStimulus(1'b0, 1'b0, NS'(1 << 1));
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("ws_issue2", 32'(bus.stage_start), 4);
        abortToIdle("ws_abort");

        // Abort in round 10, stage 2.
        runEncode(0, 10, 2, -1, 1'b0);

        // Reset during round 3 WAIT, then a full rerun from round 0.
        runEncode(0, -1, -1, 3, 1'b0);
        runEncode(0, -1, -1, -1, 1'b0);

        // Withheld stage_done: watchdog fires only in the watchdog build.
        enterFirstWait();
        for (int k = 1; k < 16; k++) begin
            checkOutput("wd_pending", 32'(bus.error), 0);
            stepCycle();
        end
        checkOutput("wd_16th", 32'(bus.error), 0);
        stepCycle();
`ifdef SCHED_TIMEOUT_EN
        checkOutput("wd_error", 32'(bus.error), 1);
        checkOutput("wd_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput("wd_held", 32'(bus.error), 1);
        end
`else
        for (int k = 0; k < 10000; k++) begin
            stepCycle();
            if (k % 1000 == 999) begin
                checkOutput("nowd_error", 32'(bus.error), 0);
                checkOutput("nowd_busy", 32'(bus.busy), 1);
            end
        end
`endif
        abortToIdle("wd_abort");

        // Done in exactly the 16th WAIT cycle still makes progress.
        enterFirstWait();
        for (int k = 1; k < 16; k++) stepCycle();
        applyStimulus(1'b0, 1'b0, NS'(1));
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("bound_issue1", 32'(bus.stage_start), 2);
        checkOutput("bound_err", 32'(bus.error), 0);
        stepCycle();
        checkOutput("bound_err_wait", 32'(bus.error), 0);
        abortToIdle("bound_abort");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
